// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multicycle control unit for the RV32I core.
//
// Steps each instruction through FETCH, DECODE and the opcode-specific
// execute / memory / writeback states. Every cycle it drives the datapath
// mux selects, the write enables and the ALU control code. It uses the ALU
// zero flag and result LSB to resolve conditional branches.
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined   : an unknown opcode traps into a sticky ILLEGAL state and
//               raises illegal_instr until reset.
//   undefined : an unknown opcode is treated as a NOP (back to FETCH), and
//               the illegal_instr port does not exist.
//
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   opcode, funct3, funct7b5  fields from the instruction register
//   zero, alu_lsb             ALU flags, used only in BRANCH
//   pc_write, ir_write,
//   reg_write, mem_write      write enables
//   adr_src, alu_src_a,
//   alu_src_b, result_src,
//   imm_src                   datapath mux selects
//   alu_ctrl                  ALU operation code
//   illegal_instr             sticky trap flag (MC_ILLEGAL_TRAP_EN only)

module multicycle_ctrl #(
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  alu_lsb,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_instr
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , ILLEGAL
`endif
  } state_t;

  state_t state;

  // funct7b5 only distinguishes SUB (R-type only) and SRA (R and I type).
  function automatic logic [ALU_CTRL_W-1:0] alu_decode(input logic [2:0] f3,
                                                       input logic       f7b5,
                                                       input logic       is_rtype);
    case (f3)
      3'b000:  alu_decode = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  function automatic logic [ALU_CTRL_W-1:0] branch_alu(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001: branch_alu = ALU_SUB;
      3'b100, 3'b101: branch_alu = ALU_SLT;
      3'b110, 3'b111: branch_alu = ALU_SLTU;
      default:        branch_alu = ALU_ADD;
    endcase
  endfunction

  // funct3 bit 0 inverts the sense of the comparison (BNE/BGE/BGEU).
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       z,
                                        input logic       lsb);
    case (f3)
      3'b000:         branch_taken = z;
      3'b001:         branch_taken = !z;
      3'b100, 3'b110: branch_taken = lsb;
      3'b101, 3'b111: branch_taken = !lsb;
      default:        branch_taken = 1'b0;
    endcase
  endfunction

  // State register and next-state decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_RTYPE:          state <= EXECUTER;
            OP_ITYPE, OP_LUI:  state <= EXECUTEI;
            OP_BRANCH:         state <= BRANCH;
            OP_JAL:            state <= JAL;
`ifdef MC_ILLEGAL_TRAP_EN
            default:           state <= ILLEGAL;
`else
            default:           state <= FETCH;
`endif
          endcase
        end
        MEMADR:   state <= (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        JAL:      state <= ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
        ILLEGAL:  state <= ILLEGAL;
`endif
        default:  state <= FETCH;
      endcase
    end
  end

  // Control outputs: decoded from state and instruction fields. Gating with
  // reset_n keeps every enable low while reset is held, even though the state
  // register already reads FETCH.
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    imm_src       = IMM_I;
    alu_ctrl      = ALU_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    if (reset_n) begin
      case (state)
        FETCH: begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
        DECODE: begin
          // Branch target (or JAL target) is precomputed into ALU-out here.
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        end
        MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        MEMREAD: begin
          adr_src = 1'b1;
        end
        MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        EXECUTER: begin
          alu_src_a = 2'b10;
          alu_ctrl  = alu_decode(funct3, funct7b5, 1'b1);
        end
        EXECUTEI: begin
          alu_src_b = 2'b01;
          if (opcode == OP_LUI) begin
            // LUI: 0 + U-immediate
            alu_src_a = 2'b11;
            imm_src   = IMM_U;
          end else begin
            alu_src_a = 2'b10;
            alu_ctrl  = alu_decode(funct3, funct7b5, 1'b0);
          end
        end
        ALUWB: begin
          reg_write = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 2'b10;
          alu_ctrl  = branch_alu(funct3);
          pc_write  = branch_taken(funct3, zero, alu_lsb);
        end
        JAL: begin
          // PC <= ALU-out (target); ALU forms the return address for ALUWB.
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        ILLEGAL: begin
          illegal_instr = 1'b1;
        end
`endif
        default: begin
          pc_write = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath mux selects, the write enables and the 4-bit ALU control code. It consumes the ALU `zero` flag and result LSB to resolve branches, so it is the driving end of the ALU control interface.

## Interface
- `ALU_CTRL_W`, 4, width of ALU control code (fixed encoding below).
- `clk` in 1 — single clock, rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `opcode` in 7 — instr[6:0] from instruction register.
- `funct3` in 3 — instr[14:12].
- `funct7b5` in 1 — instr[30].
- `zero` in 1 — ALU zero flag.
- `alu_lsb` in 1 — ALU result bit 0 (SLT/SLTU outcome).
- `pc_write` out 1 — PC register load enable.
- `ir_write` out 1 — instruction/old-PC register load enable.
- `reg_write` out 1 — register file write enable.
- `mem_write` out 1 — data memory write enable.
- `adr_src` out 1 — memory address: 0 = PC, 1 = result.
- `alu_src_a` out 2 — 00 = PC, 01 = old PC, 10 = rs1, 11 = zero.
- `alu_src_b` out 2 — 00 = rs2, 01 = immediate, 10 = constant 4.
- `result_src` out 2 — 00 = ALU-out register, 01 = memory data, 10 = ALU result direct.
- `imm_src` out 3 — I = 000, S = 001, B = 010, J = 011, U = 100.
- `alu_ctrl` out 4 — ALU operation code.
- `illegal_instr` out 1 — sticky illegal-opcode flag; present only with the macro (see Configuration).

## Operation
- ALU code encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100.
  - SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, plus ILLEGAL when the macro is defined.
- FETCH:
  - adr_src = 0, ir_write = 1.
  - ALU computes PC+4: src_a 00, src_b 10, ADD.
  - result_src = 10, pc_write = 1.
  - Next state DECODE.
- DECODE:
  - ALU computes old PC + B-immediate: src_a 01, src_b 01, imm_src 010, ADD.
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 or 0110111 → EXECUTEI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - Anything else → see Configuration.
- MEMADR: src_a 10, src_b 01, ADD; imm_src I for loads, S for stores. Next state MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adr_src = 1, result_src = 00. Next state MEMWB.
- MEMWB: result_src = 01, reg_write = 1. Next state FETCH.
- MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1. Next state FETCH.
- EXECUTER: src_a 10, src_b 00. Next state ALUWB.
- EXECUTEI: src_a 10 (11 for LUI), src_b 01, imm_src I (U for LUI; LUI forces ADD). Next state ALUWB.
- ALU code in EXECUTER/EXECUTEI, by funct3:
  - 000: SUB if R-type and funct7b5, else ADD.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
  - 101: SRA if funct7b5, else SRL.
  - 110 OR; 111 AND.
- ALUWB: result_src = 00, reg_write = 1. Next state FETCH.
- BRANCH:
  - src_a 10, src_b 00, result_src = 00.
  - funct3 000/001 → SUB, take if zero / !zero.
  - funct3 100/101 → SLT, take if alu_lsb / !alu_lsb.
  - funct3 110/111 → SLTU, same rule.
  - funct3 010/011 → never taken.
  - pc_write = take. Next state FETCH.
- JAL:
  - src_a 01, src_b 10, ADD (return address).
  - result_src = 00, pc_write = 1.
  - DECODE has already latched old PC + J-immediate in the ALU-out register; imm_src = 011 in DECODE when opcode is JAL.
  - Next state ALUWB.

## Timing
- State register updates on the rising clk edge.
- Outputs are combinational from the state and the registered instruction fields. zero and alu_lsb reach pc_write only in BRANCH.
- While reset_n is low:
  - State is FETCH, asynchronously.
  - All enables are 0; all selects and alu_ctrl are 0; illegal_instr is 0.
- On the first edge after reset_n rises, the FETCH cycle executes normally.
- Cycle counts:
  - Load 5; store 4; R-type/I-type/LUI 4.
  - Branch 3, taken or not; JAL 4.
- Reset asserted mid-instruction: abandon it immediately. Any partial writes already committed stay; no further enables assert.
- funct7b5 is ignored for I-type except funct3 = 101.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to ILLEGAL.
  - ILLEGAL holds all enables 0, sets illegal_instr = 1, and stays until reset.
- Undefined:
  - An unknown opcode in DECODE returns to FETCH (NOP, 2 cycles).
  - The illegal_instr port is absent.

## Test plan
- Reset with reset_n = 0 mid-EXECUTER → all enables 0 at once; after release, the first cycle has ir_write = 1, pc_write = 1, alu_ctrl = 0000.
- R-type SUB (opcode 0110011, funct3 000, funct7b5 1) → alu_ctrl 0001 in cycle 3, reg_write = 1 only in cycle 4, back to FETCH in cycle 5.
- I-type SRAI (0010011, 101, funct7b5 1) → 1001; with funct7b5 0 → 1000; ADDI with funct7b5 1 → 0000.
- lw → reg_write only in cycle 5 with result_src 01; sw → mem_write only in cycle 4 with adr_src 1.
- BLT (funct3 100) with alu_lsb = 1 → alu_ctrl 0101, pc_write = 1 in cycle 3; with alu_lsb = 0 → pc_write 0. BNE with zero = 1 → not taken.
- Opcode 1111111 → with MC_ILLEGAL_TRAP_EN, illegal_instr = 1 from cycle 3 and held for 10+ cycles; without it, FETCH again in cycle 3.
